exec_mul_ctrl: RTL and testbench
================================

# exec_mul_ctrl

Multi-cycle multiply sequencer for the execute stage. It accepts a 16x16 unsigned multiply from decode and computes a 32-bit product by shift-and-add over 16 cycles. Each iteration borrows the execute-stage ALU for its adder. While it runs, it owns the ALU operand/op muxes and holds the pipeline stalled; a one-cycle `done` pulse returns the product for write-back.

## Interface
Parameters:
- `MUL_ITER`, default 16: iterations per multiply; equals operand width.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — synchronous, active-low reset.
- `start`  in  1  — decode requests a multiply; `op_a` and `op_b` are valid in the same cycle.
- `op_a`  in  16  — multiplicand.
- `op_b`  in  16  — multiplier.
- `flush`  in  1  — abort any operation in progress (branch redirect).
- `busy`  out  1  — registered; high in RUN; drives the pipeline stall.
- `done`  out  1  — registered one-cycle pulse; result is valid.
- `result_lo`  out  16  — product bits [15:0]; held until the next completion.
- `result_hi`  out  16  — product bits [31:16]; held until the next completion.
- `alu_own`  out  1  — high: execute muxes select `alu_a`, `alu_b`, `alu_op` and `alu_cin` into the ALU.
- `alu_a`, `alu_b`  out  16  — ALU operands.
- `alu_op`  out  4  — ALU operation code; always `ALU_OP_ADD` while `alu_own`=1.
- `alu_cin`  out  1  — ALU carry-in; always 0.
- `alu_sum`  in  16  — ALU result, combinational in the same cycle.
- `alu_cout`  in  1  — ALU carry-out, combinational in the same cycle.

## Operation
- Internal registers:
  - `mcand[15:0]` — multiplicand.
  - `acc[15:0]` — upper product half.
  - `mq[15:0]` — multiplier / lower product half.
  - `cnt[3:0]` — iteration counter.
- States: IDLE, RUN, DONE.
- IDLE:
  - `start`=1, `flush`=0, and both operands nonzero: load `mcand`=`op_a`, `mq`=`op_b`, `acc`=0, `cnt`=0; go to RUN.
  - `start`=1 with either operand 0: go directly to DONE with product 0; the ALU is not used.
- RUN, every cycle:
  - `alu_own`=1, `alu_a`=`acc`, `alu_b` = `mq[0]` ? `mcand` : 0.
  - Next `{acc, mq}` = `{alu_cout, alu_sum, mq[15:1]}`, i.e. a 33-bit value shifted right by 1 and truncated to 32 bits.
  - `cnt` increments; at `cnt`=15 go to DONE.
- DONE:
  - `done`=1; `result_hi`/`result_lo` are loaded at the RUN→DONE transition.
  - Next cycle: `start` follows the same accept rules as IDLE (back-to-back multiply permitted); otherwise go to IDLE.
- `start` in RUN is ignored and not queued. Decode must hold the instruction, because `busy` stalls it.
- `flush` in any state: go to IDLE next cycle, no `done` pulse, result registers unchanged.
  - `flush` and `start` in the same cycle: flush wins, start dropped.
- `alu_own`=0 outside RUN. When `alu_own`=0, `alu_a`, `alu_b`, `alu_op` and `alu_cin` are 0.
- Arithmetic is unsigned and modulo 2^32; overflow is impossible.

## Timing
- Reset (`rst`=0 at an edge):
  - State IDLE.
  - `busy`, `done`, `alu_own`, `alu_cin` = 0.
  - `alu_a`, `alu_b`, `alu_op`, `result_lo`, `result_hi`, `cnt`, `acc`, `mq`, `mcand` = 0.
  - Reset mid-operation discards the operation silently.
- Normal multiply (`start` sampled at edge 0):
  - RUN during cycles 1..16.
  - `done` high in cycle 17; results valid from cycle 17 onward.
- Zero-operand multiply: `done` in cycle 1.
- Back-to-back: `start` in the DONE cycle begins RUN in the next cycle; there is no IDLE bubble.
- `busy` rises in cycle 1 and falls in cycle 17.
- `cnt` never wraps unobserved: exactly 16 RUN cycles per operation.

## Structure
- Shared package `exec_pkg` holds:
  - `ALU_OP_ADD` = 4'b0100, the ALU add encoding.
  - State encoding constants `MUL_IDLE`=2'd0, `MUL_RUN`=2'd1, `MUL_DONE`=2'd2.
  - `MUL_ITER`.
- One natural sub-module: `mul_acc_reg`. It holds the 33-to-32-bit shift register `{acc, mq}` plus `mcand`, with load, shift and hold controls.
- The FSM, counter and ALU-request muxing live in the top level.

## Test plan
- Bench ALU model: `alu_sum`/`alu_cout` = `alu_a` + `alu_b` + `alu_cin` when `alu_op`=`ALU_OP_ADD`.
- `op_a`=3, `op_b`=5, `start` at cycle 0 → `busy` for cycles 1–16; `done` at cycle 17 with hi=0x0000, lo=0x000F; `alu_own` high exactly 16 cycles.
- `op_a`=0xFFFF, `op_b`=0xFFFF → hi=0xFFFE, lo=0x0001 at cycle 17. Then `start` in the DONE cycle with 0x1234×0x0010 → hi=0x0001, lo=0x2340 at cycle 34.
- `op_a`=0x00AB, `op_b`=0 → `done` at cycle 1, result 0, `alu_own` never asserted.
- `start` with 7×9, `flush` at cycle 8 → IDLE at cycle 9, no `done`, results keep their prior values. Additional `start` pulses during cycles 2–7 are ignored.
- `rst` low at cycle 10 of 0x8000×0x0003 → all outputs 0 next cycle. A new multiply 2×2 then completes normally with lo=0x0004.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared execute-stage definitions: ALU op encodings and the multiply
// sequencer's state encoding and iteration count.
package exec_pkg;

  localparam logic [3:0] ALU_OP_ADD = 4'b0100;
  localparam int         MUL_ITER   = 16;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_acc_reg.sv
// Multiplicand register plus the {acc, mq} product shift register.
// Each shift step folds in the borrowed ALU's sum and carry-out.
module mul_acc_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        shift,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic [15:0] alu_sum,
  input  logic        alu_cout,
  output logic [15:0] mcand,
  output logic [15:0] acc,
  output logic [15:0] mq,
  output logic [31:0] shift_val
);

  logic [15:0] mcand_d, mcand_q;
  logic [15:0] acc_d, acc_q;
  logic [15:0] mq_d, mq_q;

  // Dropping bit 0 of the 33-bit {cout, sum, mq} leaves exactly 32 bits.
  assign shift_val = {alu_cout, alu_sum, mq_q[15:1]};

  // Next-value selection: load takes priority over shift, otherwise hold.
  always_comb begin
    mcand_d = mcand_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    if (load) begin
      mcand_d = op_a;
      acc_d   = 16'h0000;
      mq_d    = op_b;
    end else if (shift) begin
      acc_d = shift_val[31:16];
      mq_d  = shift_val[15:0];
    end else begin
      mcand_d = mcand_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mcand_q <= 16'h0000;
      acc_q   <= 16'h0000;
      mq_q    <= 16'h0000;
    end else begin
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
    end
  end

  assign mcand = mcand_q;
  assign acc   = acc_q;
  assign mq    = mq_q;

endmodule

// File: rtl/exec_mul_ctrl.sv
// Shift-and-add multiply sequencer that borrows the execute ALU for one
// add per iteration and stalls the pipeline while running.
module exec_mul_ctrl #(
  parameter int MUL_ITER = exec_pkg::MUL_ITER
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [15:0] result_lo,
  output logic [15:0] result_hi,
  output logic        alu_own,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_op,
  output logic        alu_cin,
  input  logic [15:0] alu_sum,
  input  logic        alu_cout
);
  import exec_pkg::*;

  localparam logic [3:0] CNT_LAST = 4'(MUL_ITER - 1);

  mul_state_e  state_d, state_q;
  logic [3:0]  cnt_d, cnt_q;
  logic        busy_d, busy_q;
  logic        done_d, done_q;
  logic [15:0] result_lo_d, result_lo_q;
  logic [15:0] result_hi_d, result_hi_q;
  logic        load_s, shift_s, accept_s, zero_s;
  logic [15:0] mcand_s, acc_s, mq_s;
  logic [31:0] shift_val_s;

  mul_acc_reg u_acc (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .shift     (shift_s),
    .op_a      (op_a),
    .op_b      (op_b),
    .alu_sum   (alu_sum),
    .alu_cout  (alu_cout),
    .mcand     (mcand_s),
    .acc       (acc_s),
    .mq        (mq_s),
    .shift_val (shift_val_s)
  );

  assign accept_s = start & ~flush;
  assign zero_s   = (op_a == 16'h0000) | (op_b == 16'h0000);

  // Next-state, counter, datapath controls and result capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load_s      = 1'b0;
    shift_s     = 1'b0;
    result_lo_d = result_lo_q;
    result_hi_d = result_hi_q;
    case (state_q)
      MUL_IDLE, MUL_DONE: begin
        if (accept_s && zero_s) begin
          state_d     = MUL_DONE;
          result_lo_d = 16'h0000;
          result_hi_d = 16'h0000;
        end else if (accept_s) begin
          state_d = MUL_RUN;
          load_s  = 1'b1;
          cnt_d   = 4'd0;
        end else begin
          state_d = MUL_IDLE;
        end
      end
      MUL_RUN: begin
        shift_s = 1'b1;
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) begin
          state_d     = MUL_DONE;
          result_hi_d = shift_val_s[31:16];
          result_lo_d = shift_val_s[15:0];
        end else begin
          state_d = MUL_RUN;
        end
      end
      default: begin
        state_d = MUL_IDLE;
      end
    endcase
    // A flush abandons everything, including a result about to be captured.
    if (flush) begin
      state_d     = MUL_IDLE;
      cnt_d       = cnt_q;
      load_s      = 1'b0;
      shift_s     = 1'b0;
      result_lo_d = result_lo_q;
      result_hi_d = result_hi_q;
    end else begin
      state_d = state_d;
    end
    busy_d = (state_d == MUL_RUN);
    done_d = (state_d == MUL_DONE);
  end

  // Control and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= MUL_IDLE;
      cnt_q       <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_lo_q <= 16'h0000;
      result_hi_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_lo_q <= result_lo_d;
      result_hi_q <= result_hi_d;
    end
  end

  // ALU request muxing, decoded purely from the state register.
  always_comb begin
    alu_own = 1'b0;
    alu_a   = 16'h0000;
    alu_b   = 16'h0000;
    alu_op  = 4'h0;
    alu_cin = 1'b0;
    if (state_q == MUL_RUN) begin
      alu_own = 1'b1;
      alu_a   = acc_s;
      alu_b   = mq_s[0] ? mcand_s : 16'h0000;
      alu_op  = ALU_OP_ADD;
    end else begin
      alu_own = 1'b0;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result_lo = result_lo_q;
  assign result_hi = result_hi_q;

endmodule

// File: tb/tb_exec_mul_ctrl.sv
// Self-checking bench for exec_mul_ctrl: table of multiplies with a product
// scoreboard, plus back-to-back, flush and mid-run reset sequences.
module tb_exec_mul_ctrl;
  import exec_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, flush, busy, done, alu_own, alu_cin, alu_cout;
  logic [15:0] op_a, op_b, result_lo, result_hi, alu_a, alu_b, alu_sum;
  logic [3:0]  alu_op;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_prod = 32'h0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] prod;
    int          lat;
    int          own;
  } vec_t;
  vec_t vecs[8];

  exec_mul_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .flush(flush), .busy(busy), .done(done), .result_lo(result_lo),
    .result_hi(result_hi), .alu_own(alu_own), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_cin(alu_cin), .alu_sum(alu_sum), .alu_cout(alu_cout)
  );

  always #5 clk = ~clk;

  // Execute-stage ALU model.
  always_comb begin
    if (alu_op == ALU_OP_ADD)
      {alu_cout, alu_sum} = 17'(alu_a) + 17'(alu_b) + 17'(alu_cin);
    else
      {alu_cout, alu_sum} = 17'h0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest pending product.
  always @(negedge clk) begin
    if (rst && done) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1, expected no done");
      end else begin
        last_prod = sb_q.pop_front();
        check("product", {result_hi, result_lo}, last_prod);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in cycle 1; runs until done or timeout, counting ALU-owned cycles.
  task automatic wait_done(output int lat, output int own, output int bad);
    lat = 1;
    own = alu_own ? 1 : 0;
    bad = (alu_own && (alu_op !== ALU_OP_ADD || alu_cin !== 1'b0)) ? 1 : 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
      if (alu_own) begin
        own++;
        if (alu_op !== ALU_OP_ADD || alu_cin !== 1'b0) bad++;
      end
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: got no done in %0d cycles, expected done", lat);
    end
  endtask

  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    tick();
    start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_busy"}, {31'h0, busy}, 32'h0);
    check({name, "_own"}, {31'h0, alu_own}, 32'h0);
    check({name, "_alu"}, {alu_a, alu_b}, 32'h0);
    check({name, "_aluop"}, {27'h0, alu_op, alu_cin}, 32'h0);
  endtask

  initial begin
    int lat, own, bad;
    vecs[0] = '{16'h0003, 16'h0005, 32'h0000_000F, 17, 16};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 17, 16};
    vecs[2] = '{16'h00AB, 16'h0000, 32'h0000_0000, 1, 0};
    vecs[3] = '{16'h0000, 16'h1234, 32'h0000_0000, 1, 0};
    vecs[4] = '{16'h8000, 16'h0003, 32'h0001_8000, 17, 16};
    vecs[5] = '{16'h1234, 16'h0010, 32'h0001_2340, 17, 16};
    vecs[6] = '{16'hFFFF, 16'h0001, 32'h0000_FFFF, 17, 16};
    vecs[7] = '{16'h1234, 16'h5678, 32'h0626_0060, 17, 16};

    rst = 1'b0; start = 1'b0; flush = 1'b0; op_a = 16'h0; op_b = 16'h0;
    tick();
    tick();
    check("reset_done", {31'h0, done}, 32'h0);
    check("reset_result", {result_hi, result_lo}, 32'h0);
    check_idle_outputs("reset");
    rst = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      sb_q.push_back(vecs[i].prod);
      launch(vecs[i].a, vecs[i].b);
      check("busy_c1", {31'h0, busy}, (vecs[i].lat > 1) ? 32'h1 : 32'h0);
      wait_done(lat, own, bad);
      check("latency", lat, vecs[i].lat);
      check("own_cycles", own, vecs[i].own);
      check("alu_op_cin", bad, 0);
      check("busy_at_done", {31'h0, busy}, 32'h0);
      tick();
      check("done_pulse", {31'h0, done}, 32'h0);
      check("result_held", {result_hi, result_lo}, vecs[i].prod);
      check_idle_outputs("post");
    end

    // Back-to-back: second start issued in the DONE cycle of the first.
    sb_q.push_back(32'hFFFE_0001);
    launch(16'hFFFF, 16'hFFFF);
    wait_done(lat, own, bad);
    check("b2b_lat1", lat, 17);
    sb_q.push_back(32'h0001_2340);
    launch(16'h1234, 16'h0010);
    check("b2b_no_bubble", {31'h0, busy}, 32'h1);
    wait_done(lat, own, bad);
    check("b2b_lat2", lat, 17);
    check("b2b_own", own, 16);
    tick();

    // Flush at cycle 8 with extra starts in cycles 2..7.
    launch(16'h0007, 16'h0009);
    for (int c = 1; c <= 7; c++) begin
      start = (c >= 2);
      op_a  = 16'h0001;
      op_b  = 16'h0001;
      tick();
    end
    start = 1'b0;
    check("flush_busy_c8", {31'h0, busy}, 32'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_done", {31'h0, done}, 32'h0);
    check_idle_outputs("flush");
    check("flush_result", {result_hi, result_lo}, 32'h0001_2340);
    for (int c = 0; c < 20; c++) tick();
    check("flush_quiet", {31'h0, done | busy}, 32'h0);
    check("flush_result_late", {result_hi, result_lo}, 32'h0001_2340);

    // Reset at cycle 10 of 0x8000 x 3, then 2 x 2.
    launch(16'h8000, 16'h0003);
    for (int c = 1; c < 10; c++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_result", {result_hi, result_lo}, 32'h0);
    check_idle_outputs("rst");
    sb_q.push_back(32'h0000_0004);
    launch(16'h0002, 16'h0002);
    wait_done(lat, own, bad);
    check("rst_next_lat", lat, 17);
    tick();
    check("rst_next_lo", {16'h0, result_lo}, 32'h0000_0004);
    check("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
